// File: rtl/stone_paper_scissors.sv
// ---------------------------------------------------------------------------
// stone_paper_scissors
//
// Two-player stone/paper/scissors referee packaged as a Tiny Tapeout user
// tile. Each rising edge of the start input judges one round from the two
// players' moves. The tile keeps a registered winner code, a win score for
// each player and a round counter.
//
// Move code:   00 = stone, 01 = paper, 10 = scissors, 11 = invalid
// Winner code: 00 = tie,   01 = P1 wins, 10 = P2 wins, 11 = invalid round
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   ena      in   1  tile enable; ignored, the design is always active
//   ui_in    in   8  [1:0] P1 move, [3:2] P2 move, [4] start, [5] clear
//   uo_out   out  8  [1:0] winner, [2] result_valid, [3] new_result,
//                    [7:4] round_count
//   uio_in   in   8  unused
//   uio_out  out  8  [3:0] P1 score, [7:4] P2 score
//   uio_oe   out  8  constant 8'hFF, all uio pins are outputs
// ---------------------------------------------------------------------------
module stone_paper_scissors (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] MOVE_STONE    = 2'b00;
    localparam logic [1:0] MOVE_PAPER    = 2'b01;
    localparam logic [1:0] MOVE_SCISSORS = 2'b10;
    localparam logic [1:0] MOVE_INVALID  = 2'b11;

    localparam logic [1:0] WIN_TIE     = 2'b00;
    localparam logic [1:0] WIN_P1      = 2'b01;
    localparam logic [1:0] WIN_P2      = 2'b10;
    localparam logic [1:0] WIN_INVALID = 2'b11;

    logic [1:0] p1_move;
    logic [1:0] p2_move;
    logic       start;
    logic       clear;

    logic       start_q;
    logic       fire;
    logic [1:0] round_code;

    logic [1:0] winner;
    logic       result_valid;
    logic       new_result;
    logic [3:0] round_count;
    logic [3:0] p1_score;
    logic [3:0] p2_score;

    // Pins that carry no function are folded into one named sink.
    logic unused_bits;

    assign p1_move = ui_in[1:0];
    assign p2_move = ui_in[3:2];
    assign start   = ui_in[4];
    assign clear   = ui_in[5];

    assign unused_bits = ^{ena, uio_in, ui_in[7:6]};

    // A round fires only on the first cycle start is seen high.
    assign fire = start & ~start_q;

    // Judge the current moves; only used on the firing edge.
    always_comb begin
        round_code = WIN_P2;
        if (p1_move == MOVE_INVALID || p2_move == MOVE_INVALID) begin
            round_code = WIN_INVALID;
        end else if (p1_move == p2_move) begin
            round_code = WIN_TIE;
        end else if ((p1_move == MOVE_STONE    && p2_move == MOVE_SCISSORS) ||
                     (p1_move == MOVE_PAPER    && p2_move == MOVE_STONE)    ||
                     (p1_move == MOVE_SCISSORS && p2_move == MOVE_PAPER)) begin
            round_code = WIN_P1;
        end
    end

    // Clear beats a firing round on the same edge, so that round is dropped
    // and no new_result pulse is produced. Scores stop at 15, while the
    // round counter wraps and also counts invalid rounds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            winner       <= WIN_TIE;
            result_valid <= 1'b0;
            new_result   <= 1'b0;
            round_count  <= 4'd0;
            p1_score     <= 4'd0;
            p2_score     <= 4'd0;
        end else begin
            start_q    <= start;
            new_result <= 1'b0;
            if (clear) begin
                winner       <= WIN_TIE;
                result_valid <= 1'b0;
                round_count  <= 4'd0;
                p1_score     <= 4'd0;
                p2_score     <= 4'd0;
            end else if (fire) begin
                winner       <= round_code;
                result_valid <= 1'b1;
                new_result   <= 1'b1;
                round_count  <= round_count + 4'd1;
                if (round_code == WIN_P1 && p1_score != 4'hF) begin
                    p1_score <= p1_score + 4'd1;
                end
                if (round_code == WIN_P2 && p2_score != 4'hF) begin
                    p2_score <= p2_score + 4'd1;
                end
            end
        end
    end

    assign uo_out  = {round_count, new_result, result_valid, winner};
    assign uio_out = {p2_score, p1_score};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_stone_paper_scissors.sv
// ---------------------------------------------------------------------------
// tb_stone_paper_scissors
//
// Directed self-checking bench for stone_paper_scissors. Inputs change on
// the falling clock edge; outputs are sampled 1 ns after the rising edge.
// Expected values are hand-computed and packed into the pin layout.
// ---------------------------------------------------------------------------
module tb_stone_paper_scissors;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checkCount;
    int passCount;

    stone_paper_scissors dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and log a miss.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Pack expected uo_out fields.
    function automatic logic [7:0] uo(input int round, input logic newRes,
                                      input logic valid, input logic [1:0] win);
        uo = {round[3:0], newRes, valid, win};
    endfunction

    // Pack expected scores.
    function automatic logic [7:0] sc(input int p1, input int p2);
        sc = {p2[3:0], p1[3:0]};
    endfunction

    // Raise start (plus optional clear) with the given moves, then let one
    // rising edge pass and stop 1 ns after it.
    task automatic applyStimulus(input logic [1:0] p1, input logic [1:0] p2,
                                 input logic clr);
        @(negedge clk);
        ui_in = {2'b00, clr, 1'b1, p2, p1};
        @(posedge clk);
        #1;
    endtask

    // Drop start and clear, keep moves, and let one rising edge pass.
    task automatic idleCycle();
        @(negedge clk);
        ui_in[5:4] = 2'b00;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        ena        = 1'b1;
        uio_in     = 8'h00;
        ui_in      = 8'h00;
        rst_n      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_uo", uo_out, 8'h00);
        checkOutput("reset_uio", uio_out, 8'h00);
        checkOutput("uio_oe", uio_oe, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycle();
        checkOutput("idle_after_reset", uo_out, 8'h00);

        // Stone beats scissors
        applyStimulus(2'b00, 2'b10, 1'b0);
        checkOutput("r1_uo", uo_out, uo(1, 1'b1, 1'b1, 2'b01));
        checkOutput("r1_score", uio_out, sc(1, 0));
        idleCycle();
        checkOutput("r1_pulse_end", uo_out, uo(1, 1'b0, 1'b1, 2'b01));

        // Paper beats stone, scissors beats paper
        applyStimulus(2'b01, 2'b00, 1'b0);
        checkOutput("r2_uo", uo_out, uo(2, 1'b1, 1'b1, 2'b01));
        idleCycle();
        applyStimulus(2'b10, 2'b01, 1'b0);
        checkOutput("r3_uo", uo_out, uo(3, 1'b1, 1'b1, 2'b01));
        checkOutput("r3_score", uio_out, sc(3, 0));
        idleCycle();

        // P2 win, then a tie
        applyStimulus(2'b00, 2'b01, 1'b0);
        checkOutput("r4_uo", uo_out, uo(4, 1'b1, 1'b1, 2'b10));
        checkOutput("r4_score", uio_out, sc(3, 1));
        idleCycle();
        applyStimulus(2'b01, 2'b01, 1'b0);
        checkOutput("r5_tie_uo", uo_out, uo(5, 1'b1, 1'b1, 2'b00));
        checkOutput("r5_tie_score", uio_out, sc(3, 1));
        idleCycle();

        // Invalid move still counts as a round
        applyStimulus(2'b11, 2'b00, 1'b0);
        checkOutput("r6_invalid_uo", uo_out, uo(6, 1'b1, 1'b1, 2'b11));
        checkOutput("r6_invalid_score", uio_out, sc(3, 1));
        idleCycle();

        // Moves changing while start stays low have no effect
        @(negedge clk);
        ui_in[3:0] = 4'b1000;
        @(posedge clk);
        #1;
        checkOutput("no_fire_uo", uo_out, uo(6, 1'b0, 1'b1, 2'b11));
        checkOutput("no_fire_score", uio_out, sc(3, 1));

        // Start held high for five cycles fires once
        applyStimulus(2'b00, 2'b10, 1'b0);
        checkOutput("hold_first", uo_out, uo(7, 1'b1, 1'b1, 2'b01));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold_%0d", i), uo_out, uo(7, 1'b0, 1'b1, 2'b01));
        end
        checkOutput("hold_score", uio_out, sc(4, 1));
        idleCycle();

        // Plain clear
        @(negedge clk);
        ui_in = 8'h20;
        @(posedge clk);
        #1;
        checkOutput("clear_uo", uo_out, 8'h00);
        checkOutput("clear_score", uio_out, 8'h00);
        idleCycle();

        // 17 P1 wins: score saturates, round count wraps to 1
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(2'b01, 2'b00, 1'b0);
            if (i == 16) begin
                checkOutput("wrap_round0", uo_out, uo(0, 1'b1, 1'b1, 2'b01));
                checkOutput("sat_16", uio_out, sc(15, 0));
            end
            idleCycle();
        end
        checkOutput("wrap_round1", uo_out, uo(1, 1'b0, 1'b1, 2'b01));
        checkOutput("sat_17", uio_out, sc(15, 0));

        // Clear together with a start edge discards the round
        applyStimulus(2'b00, 2'b10, 1'b1);
        checkOutput("clear_start_uo", uo_out, 8'h00);
        checkOutput("clear_start_score", uio_out, 8'h00);
        idleCycle();
        checkOutput("clear_start_after", uo_out, 8'h00);

        // Asynchronous reset in the middle of a cycle
        applyStimulus(2'b10, 2'b00, 1'b0);
        checkOutput("pre_reset_uo", uo_out, uo(1, 1'b1, 1'b1, 2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_uo", uo_out, 8'h00);
        checkOutput("async_reset_score", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        ui_in = 8'h00;
        idleCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
